// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - direct-mapped cache tag lookup controller
module cache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH  = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_write,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [INDEX_WIDTH-1:0] resp_index,
  output logic                   miss_valid,
  output logic                   miss_victim_dirty,
  output logic [TAG_WIDTH-1:0]   miss_victim_tag,
  input  logic                   fill_done,
  output logic                   tag_csb,
  output logic                   tag_web,
  output logic [INDEX_WIDTH-1:0] tag_addr,
  output logic [TAG_WIDTH-1:0]   tag_din,
  input  logic [TAG_WIDTH-1:0]   tag_dout
);

  localparam int SETS = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, CMP, MISS, RESP} state_t;

  state_t                 state, state_nxt;
  logic [SETS-1:0]        valid, dirty;
  logic [INDEX_WIDTH-1:0] lat_index;
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic                   lat_write;
  logic                   accept, fill, hit;

  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   unused_offset;

  assign req_index     = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag       = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  // tag_dout is only meaningful in CMP, one cycle after the read was issued
  assign hit = valid[lat_index] && (tag_dout == lat_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    fill      = 1'b0;
    tag_csb   = 1'b1;
    tag_web   = 1'b1;
    tag_addr  = lat_index;
    tag_din   = lat_tag;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          accept    = 1'b1;
          tag_csb   = 1'b0;
          tag_addr  = req_index;
          state_nxt = CMP;
        end
      end
      CMP:  state_nxt = hit ? RESP : MISS;
      MISS: begin
        if (fill_done) begin
          fill      = 1'b1;
          tag_csb   = 1'b0;
          tag_web   = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid             <= '0;
      dirty             <= '0;
      lat_index         <= '0;
      lat_tag           <= '0;
      lat_write         <= 1'b0;
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_index        <= '0;
      miss_valid        <= 1'b0;
      miss_victim_dirty <= 1'b0;
      miss_victim_tag   <= '0;
    end else begin
      if (accept) begin
        lat_index <= req_index;
        lat_tag   <= req_tag;
        lat_write <= req_write;
      end
      if (state == CMP) begin
        if (hit) begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b1;
          resp_index <= lat_index;
          if (lat_write) dirty[lat_index] <= 1'b1;
        end else begin
          miss_valid        <= 1'b1;
          miss_victim_dirty <= valid[lat_index] & dirty[lat_index];
          miss_victim_tag   <= tag_dout;
        end
      end
      if (fill) begin
        valid[lat_index] <= 1'b1;
        dirty[lat_index] <= lat_write;
        miss_valid       <= 1'b0;
        resp_valid       <= 1'b1;
        resp_hit         <= 1'b0;
        resp_index       <= lat_index;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - directed self-checking bench for cache_tag_ctrl
module tb_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic [3:0]  resp_index;
  logic        miss_valid;
  logic        miss_victim_dirty;
  logic [22:0] miss_victim_tag;
  logic        fill_done = 1'b0;
  logic        tag_csb;
  logic        tag_web;
  logic [3:0]  tag_addr;
  logic [22:0] tag_din;
  logic [22:0] tag_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_tag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_index(resp_index),
    .miss_valid(miss_valid), .miss_victim_dirty(miss_victim_dirty), .miss_victim_tag(miss_victim_tag),
    .fill_done(fill_done),
    .tag_csb(tag_csb), .tag_web(tag_web), .tag_addr(tag_addr), .tag_din(tag_din), .tag_dout(tag_dout)
  );

  // tag SRAM model: samples at posedge, updates array/dout at the following negedge
  logic [22:0] mem [16];
  logic        s_act = 1'b0, s_we = 1'b0;
  logic [3:0]  s_addr = '0;
  logic [22:0] s_din = '0;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    s_act  <= !tag_csb;
    s_we   <= !tag_web;
    s_addr <= tag_addr;
    s_din  <= tag_din;
  end

  always @(negedge clk) begin
    if (s_act) begin
      if (s_we) mem[s_addr] <= s_din;
      else      tag_dout    <= mem[s_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] addr, input logic wr);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    #1;
    chk("acc_ready", req_ready, 1);
    chk("acc_csb", tag_csb, 0);
    chk("acc_web", tag_web, 1);
    chk("acc_addr", tag_addr, addr[8:5]);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_hit(input logic [3:0] idx);
    #1;
    chk("cmp_resp_valid", resp_valid, 0);
    chk("cmp_csb", tag_csb, 1);
    tick();
    chk("hit_resp_valid", resp_valid, 1);
    chk("hit_resp_hit", resp_hit, 1);
    chk("hit_resp_index", resp_index, idx);
    chk("hit_no_miss", miss_valid, 0);
  endtask

  task automatic expect_miss(input logic vdirty, input logic [22:0] vtag);
    tick();
    chk("miss_valid", miss_valid, 1);
    chk("miss_victim_dirty", miss_victim_dirty, vdirty);
    chk("miss_victim_tag", miss_victim_tag, vtag);
    chk("miss_resp_valid", resp_valid, 0);
  endtask

  task automatic do_fill(input logic [3:0] idx, input logic [22:0] tag);
    fill_done = 1'b1;
    #1;
    chk("fill_csb", tag_csb, 0);
    chk("fill_web", tag_web, 0);
    chk("fill_addr", tag_addr, idx);
    chk("fill_din", tag_din, tag);
    tick();
    fill_done = 1'b0;
    chk("fill_resp_valid", resp_valid, 1);
    chk("fill_resp_hit", resp_hit, 0);
    chk("fill_resp_index", resp_index, idx);
    chk("fill_miss_clr", miss_valid, 0);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("done_resp_valid", resp_valid, 0);
    chk("done_req_ready", req_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_csb", tag_csb, 1);
    chk("rst_web", tag_web, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_miss_valid", miss_valid, 0);
    chk("rst_victim_tag", miss_victim_tag, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);

    // fill_done in IDLE is ignored
    fill_done = 1'b1;
    #1;
    chk("idle_fill_csb", tag_csb, 1);
    tick();
    fill_done = 1'b0;
    chk("idle_fill_ready", req_ready, 1);

    // cold load miss on set 1, with a stray fill_done during CMP
    accept(32'h0000_1234, 1'b0);
    fill_done = 1'b1;
    #1;
    chk("cmp_fill_csb", tag_csb, 1);
    chk("cmp_fill_web", tag_web, 1);
    expect_miss(1'b0, 23'h0);
    fill_done = 1'b0;
    tick();
    chk("miss_hold_valid", miss_valid, 1);
    chk("miss_hold_csb", tag_csb, 1);
    do_fill(4'd1, 23'h9);
    finish_resp();

    // load hit, then resp_ready held low for 5 cycles
    accept(32'h0000_1234, 1'b0);
    expect_hit(4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_hit", resp_hit, 1);
      chk("stall_resp_index", resp_index, 1);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_csb", tag_csb, 1);
    end
    finish_resp();

    // store hit dirties set 1; conflicting load sees dirty victim
    accept(32'h0000_1238, 1'b1);
    expect_hit(4'd1);
    finish_resp();
    accept(32'h0000_1434, 1'b0);
    expect_miss(1'b1, 23'h9);
    do_fill(4'd1, 23'hA);
    finish_resp();

    // load refill left set 1 clean; reset while in MISS
    accept(32'h0000_1234, 1'b0);
    expect_miss(1'b0, 23'hA);
    rst_n = 1'b0;
    #1;
    chk("async_miss_valid", miss_valid, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_csb", tag_csb, 1);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    accept(32'h0000_1434, 1'b0);
    expect_miss(1'b0, 23'hA);
    do_fill(4'd1, 23'hA);
    finish_resp();

    // store miss leaves the line dirty
    accept(32'h0000_2000, 1'b1);
    expect_miss(1'b0, 23'h0);
    do_fill(4'd0, 23'h10);
    finish_resp();
    accept(32'h0000_4000, 1'b0);
    expect_miss(1'b1, 23'h10);
    do_fill(4'd0, 23'h20);
    finish_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
